// File: rtl/mandelbrot_iterator_if.sv
// Handshake bundle between the pixel-coordinate generator, the escape-time
// engine and the colour converter. The engine connects through the slave
// modport. Its environment (generator side and converter side) connects
// through the master modport.
interface mandelbrot_iterator_if #(
    parameter int WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] c_re;
    logic signed [WIDTH-1:0] c_im;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              iteration;
    logic                    ismandelbrot;

    modport master (
        output in_valid, c_re, c_im, out_ready,
        input  in_ready, out_valid, iteration, ismandelbrot
    );

    modport slave (
        input  in_valid, c_re, c_im, out_ready,
        output in_ready, out_valid, iteration, ismandelbrot
    );
endinterface

// File: rtl/mandelbrot_iterator.sv
// Escape-time engine for a single pixel. It iterates z = z^2 + c from z = 0
// in signed fixed point and checks |z|^2 > 4 once per cycle. It reports the
// escape count, or MAX_ITER together with an in-set flag.
//
// Optional build macro MANDEL_SAT_EN: when defined, z updates saturate
// instead of wrapping. Escape detection is unchanged.
//
// state   | meaning
// IDLE    | waiting for a point; in_ready high
// ITERATE | one escape check / z update per cycle; busy high
// DONE    | result presented; out_valid high until out_ready
module mandelbrot_iterator #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 12,
    parameter int MAX_ITER = 255
) (
    input  logic                  clk,
    input  logic                  nrst,
    mandelbrot_iterator_if.slave  bus,
    output logic                  busy
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW:0] THRESH = (PW + 1)'(4) << (2 * FRAC);
    localparam logic [7:0]         CAP    = 8'(MAX_ITER);

    typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;

    state_t                  state, state_nxt;
    logic signed [WIDTH-1:0] z_re, z_im, cr, ci;
    logic [7:0]              count;
    logic [7:0]              iter_q;
    logic                    inset_q;

    logic signed [PW-1:0]    rr, ii, ri;
    logic signed [PW:0]      mag, diff, twice, re_shift, im_shift;
    logic signed [PW+1:0]    re_sum, im_sum;
    logic signed [WIDTH-1:0] re_nxt, im_nxt;
    logic                    escape, at_cap;

    // Full-precision squares, escape test and the next z candidate.
    always_comb begin
        rr       = z_re * z_re;
        ii       = z_im * z_im;
        ri       = z_re * z_im;
        mag      = rr + ii;
        diff     = rr - ii;
        twice    = $signed({ri, 1'b0});
        re_shift = diff >>> FRAC;
        im_shift = twice >>> FRAC;
        re_sum   = re_shift + cr;
        im_sum   = im_shift + ci;
        escape   = mag > THRESH;
        at_cap   = count == CAP;
    end

`ifdef MANDEL_SAT_EN
    localparam logic signed [PW+1:0] ZMAX = $signed({{(PW + 3 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}});
    localparam logic signed [PW+1:0] ZMIN = $signed({{(PW + 3 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}});

    // Clamp the next z into the representable range.
    always_comb begin
        re_nxt = re_sum[WIDTH-1:0];
        im_nxt = im_sum[WIDTH-1:0];
        if (re_sum > ZMAX)      re_nxt = {1'b0, {(WIDTH - 1){1'b1}}};
        else if (re_sum < ZMIN) re_nxt = {1'b1, {(WIDTH - 1){1'b0}}};
        if (im_sum > ZMAX)      im_nxt = {1'b0, {(WIDTH - 1){1'b1}}};
        else if (im_sum < ZMIN) im_nxt = {1'b1, {(WIDTH - 1){1'b0}}};
    end
`else
    logic unused_hi;

    // Two's-complement wrap: keep only the low WIDTH bits.
    always_comb begin
        re_nxt    = re_sum[WIDTH-1:0];
        im_nxt    = im_sum[WIDTH-1:0];
        unused_hi = ^{re_sum[PW+1:WIDTH], im_sum[PW+1:WIDTH]};
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = ITERATE;
            end
            ITERATE: begin
                busy = 1'b1;
                if (escape || at_cap) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch c on accept, iterate z, capture the result on exit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            z_re    <= '0;
            z_im    <= '0;
            cr      <= '0;
            ci      <= '0;
            count   <= '0;
            iter_q  <= '0;
            inset_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cr    <= bus.c_re;
                        ci    <= bus.c_im;
                        z_re  <= '0;
                        z_im  <= '0;
                        count <= '0;
                    end
                end
                ITERATE: begin
                    if (escape) begin
                        iter_q  <= count;
                        inset_q <= 1'b0;
                    end else if (at_cap) begin
                        iter_q  <= CAP;
                        inset_q <= 1'b1;
                    end else begin
                        z_re  <= re_nxt;
                        z_im  <= im_nxt;
                        count <= count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.iteration    = iter_q;
    assign bus.ismandelbrot = inset_q;
endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Directed bench for the escape-time engine, using hand-computed Q4.12 vectors.
module tb_mandelbrot_iterator;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic busy;
    int   errs = 0;
    int   checks = 0;

    mandelbrot_iterator_if #(.WIDTH(16)) bus ();

    mandelbrot_iterator #(.WIDTH(16), .FRAC(12), .MAX_ITER(255)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a point and return just after the accept edge.
    task automatic send(input logic [15:0] cre, input logic [15:0] cim);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.c_re     = cre;
        bus.c_im     = cim;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Called just after the accept edge; waits for out_valid and checks the result.
    task automatic collect(input string tag, input int exp_iter, input logic exp_in);
        int edges = 0;
        int busy_cnt;
        busy_cnt = busy ? 1 : 0;
        while (!bus.out_valid && edges < 400) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cnt++;
        end
        chk({tag, " latency"}, edges, exp_iter + 1);
        chk({tag, " iteration"}, bus.iteration, exp_iter);
        chk({tag, " ismandelbrot"}, bus.ismandelbrot, exp_in);
        chk({tag, " busy cycles"}, busy_cnt, exp_iter + 1);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " out_valid drop"}, bus.out_valid, 0);
        chk({tag, " in_ready back"}, bus.in_ready, 1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       stable;
        logic       seen;
        logic [7:0] it0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.c_re      = '0;
        bus.c_im      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst iteration", bus.iteration, 0);
        chk("rst ismandelbrot", bus.ismandelbrot, 0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("rst in_ready", bus.in_ready, 1);

        // c = 0 never escapes: full 256-cycle run
        send(16'h0000, 16'h0000);
        collect("c0", 255, 1'b1);
        release_out("c0");

        // c = 3.0 escapes at count 1
        send(16'h3000, 16'h0000);
        collect("c3", 1, 1'b0);
        release_out("c3");

        // c = -2.0 sticks at z = 2, |z|^2 == 4 never escapes
        send(16'hE000, 16'h0000);
        collect("cm2", 255, 1'b1);
        release_out("cm2");

        // c = 1.0: z = 1, 2, 5 -> escapes at count 3
        send(16'h1000, 16'h0000);
        collect("c1", 3, 1'b0);
        release_out("c1");

        // c = 0.5: z = .5, .75, 1.0625, 1.6289, 3.153 -> escapes at count 5
        send(16'h0800, 16'h0000);
        collect("c05", 5, 1'b0);
        release_out("c05");

        // c = i: period-2 cycle -1+i, -i -> in set
        send(16'h0000, 16'h1000);
        collect("ci", 255, 1'b1);
        release_out("ci");

        // c = 2.0: |z|^2 == 4 at count 1 does not escape, z = 6 escapes at count 2
        send(16'h2000, 16'h0000);
        collect("c2", 2, 1'b0);

        // Hold DONE for 10 cycles while upstream offers c = 3.0
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.c_re     = 16'h3000;
        bus.c_im     = 16'h0000;
        stable = 1'b1;
        it0 = bus.iteration;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid || bus.in_ready || busy || bus.iteration !== it0 || bus.ismandelbrot !== 1'b0)
                stable = 1'b0;
        end
        chk("hold stable", stable, 1);
        chk("hold iteration", bus.iteration, 2);

        // out_ready and in_valid together: only the output handshake completes
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("both out_valid", bus.out_valid, 0);
        chk("both in_ready", bus.in_ready, 1);
        chk("both busy", busy, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("next accept busy", busy, 1);
        collect("c3b", 1, 1'b0);
        release_out("c3b");

        // Reset mid-ITERATE discards the run
        send(16'h0000, 16'h0000);
        repeat (50) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst out_valid", bus.out_valid, 0);
        chk("midrst iteration", bus.iteration, 0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("midrst in_ready", bus.in_ready, 1);
        seen = 1'b0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || busy) seen = 1'b1;
        end
        chk("midrst no result", seen, 0);
        send(16'h3000, 16'h0000);
        collect("post rst c3", 1, 1'b0);
        release_out("post rst c3");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
